// File: rtl/adc_sample_reader.sv
// adc_sample_reader
//
// Acquisition front end for the PI control loop. On a start request it
// pulses the ADC convert line for a fixed conversion time, then clocks
// ADC_WID bits out of the ADC over a small SPI-style read (MSB first) and
// presents the result as a signed two's-complement sample. The consumer
// sign-extends it as needed.
//
// Ports:
//   clk       in   system clock
//   rst_L     in   synchronous reset, active low
//   arm       in   start request, held by the consumer until finished
//   adc_conv  out  convert strobe to the ADC, active high
//   adc_sck   out  serial clock to the ADC (idles at POLARITY)
//   adc_in    in   ADC serial data (MISO)
//   measured  out  last completed sample, signed, ADC_WID bits
//   finished  out  sample valid / transaction done
//   railed    out  sample sits at either rail (ADC_RAIL_DETECT_EN only)
//
// Optional feature macro: ADC_RAIL_DETECT_EN adds the railed output, which
// flags a full-scale positive or negative sample and is updated together
// with measured.

module adc_sample_reader #(
    parameter int ADC_WID         = 18,
    parameter int WID_LEN         = 5,
    parameter int CONV_WAIT       = 20,
    parameter int CONV_WAIT_LEN   = 6,
    parameter int CYCLE_HALF_WAIT = 1,
    parameter int TIMER_LEN       = 3,
    parameter int POLARITY        = 1,
    parameter int PHASE           = 0
) (
    input  logic               clk,
    input  logic               rst_L,
    input  logic               arm,
    output logic               adc_conv,
    output logic               adc_sck,
    input  logic               adc_in,
    output logic [ADC_WID-1:0] measured,
    output logic               finished
`ifdef ADC_RAIL_DETECT_EN
    ,
    output logic               railed
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        DONE
    } state_t;

    localparam logic SCK_IDLE = 1'(POLARITY);

    state_t                   state_q, state_d;
    logic [CONV_WAIT_LEN-1:0] convCnt_q, convCnt_d;
    logic [TIMER_LEN-1:0]     halfCnt_q, halfCnt_d;
    logic [WID_LEN-1:0]       bitCnt_q, bitCnt_d;
    logic [ADC_WID-1:0]       shiftReg_q, shiftReg_d;
    logic [ADC_WID-1:0]       measured_q, measured_d;
    logic                     sck_q, sck_d;
    logic                     conv_q, conv_d;
    logic                     finished_q, finished_d;

`ifdef ADC_RAIL_DETECT_EN
    localparam logic [ADC_WID-1:0] RAIL_POS = {1'b0, {(ADC_WID-1){1'b1}}};
    localparam logic [ADC_WID-1:0] RAIL_NEG = {1'b1, {(ADC_WID-1){1'b0}}};
    logic railed_q, railed_d;
`endif

    // State and datapath registers. Reset clears everything, so an aborted
    // read never leaves a partial sample behind in measured.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_q    <= IDLE;
            convCnt_q  <= '0;
            halfCnt_q  <= '0;
            bitCnt_q   <= '0;
            shiftReg_q <= '0;
            measured_q <= '0;
            sck_q      <= SCK_IDLE;
            conv_q     <= 1'b0;
            finished_q <= 1'b0;
`ifdef ADC_RAIL_DETECT_EN
            railed_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            convCnt_q  <= convCnt_d;
            halfCnt_q  <= halfCnt_d;
            bitCnt_q   <= bitCnt_d;
            shiftReg_q <= shiftReg_d;
            measured_q <= measured_d;
            sck_q      <= sck_d;
            conv_q     <= conv_d;
            finished_q <= finished_d;
`ifdef ADC_RAIL_DETECT_EN
            railed_q   <= railed_d;
`endif
        end
    end

    // Next-state logic. SHIFT counts completed SCK periods rather than
    // toggles so the bit counter only has to reach ADC_WID. Once the last
    // trailing toggle has returned SCK to idle, the FSM spends one more
    // cycle in SHIFT before committing the sample on entry to DONE.
    always_comb begin
        state_d    = state_q;
        convCnt_d  = convCnt_q;
        halfCnt_d  = halfCnt_q;
        bitCnt_d   = bitCnt_q;
        shiftReg_d = shiftReg_q;
        measured_d = measured_q;
        sck_d      = sck_q;
        conv_d     = conv_q;
        finished_d = finished_q;
`ifdef ADC_RAIL_DETECT_EN
        railed_d   = railed_q;
`endif

        unique case (state_q)
            IDLE: begin
                sck_d      = SCK_IDLE;
                finished_d = 1'b0;
                if (arm) begin
                    state_d   = CONV;
                    conv_d    = 1'b1;
                    convCnt_d = '0;
                end
            end

            CONV: begin
                if (convCnt_q == CONV_WAIT_LEN'(CONV_WAIT - 1)) begin
                    state_d    = SHIFT;
                    conv_d     = 1'b0;
                    halfCnt_d  = '0;
                    bitCnt_d   = '0;
                    shiftReg_d = '0;
                    sck_d      = SCK_IDLE;
                end else begin
                    convCnt_d = convCnt_q + CONV_WAIT_LEN'(1);
                end
            end

            SHIFT: begin
                if (bitCnt_q == WID_LEN'(ADC_WID)) begin
                    state_d    = DONE;
                    measured_d = shiftReg_q;
                    finished_d = 1'b1;
`ifdef ADC_RAIL_DETECT_EN
                    railed_d   = (shiftReg_q == RAIL_POS) || (shiftReg_q == RAIL_NEG);
`endif
                end else if (halfCnt_q == TIMER_LEN'(CYCLE_HALF_WAIT)) begin
                    halfCnt_d = '0;
                    sck_d     = ~sck_q;
                    // Leaving the idle level is the leading edge of a period;
                    // returning to it is the trailing edge and closes the period.
                    if (sck_q == SCK_IDLE) begin
                        if (PHASE == 0) begin
                            shiftReg_d = {shiftReg_q[ADC_WID-2:0], adc_in};
                        end
                    end else begin
                        if (PHASE != 0) begin
                            shiftReg_d = {shiftReg_q[ADC_WID-2:0], adc_in};
                        end
                        bitCnt_d = bitCnt_q + WID_LEN'(1);
                    end
                end else begin
                    halfCnt_d = halfCnt_q + TIMER_LEN'(1);
                end
            end

            DONE: begin
                if (!arm) begin
                    state_d    = IDLE;
                    finished_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign adc_conv = conv_q;
    assign adc_sck  = sck_q;
    assign measured = measured_q;
    assign finished = finished_q;
`ifdef ADC_RAIL_DETECT_EN
    assign railed   = railed_q;
`endif

endmodule

// File: tb/tb_adc_sample_reader.sv
// tb_adc_sample_reader
//
// Runs four adc_sample_reader instances in lockstep, one per SCK mode
// (POLARITY x PHASE), each driven by its own ADC model serving the same
// sample word. Mode 0 uses the default POLARITY=1, PHASE=0. Expected
// results are queued when a read is started and checked by a per-instance
// monitor whenever finished rises.

module tb_adc_sample_reader;

    localparam int W     = 18;
    localparam int CW    = 20;
    localparam int CHW   = 1;
    localparam int LAT   = 1 + CW + 2 * W * (CHW + 1);
    localparam int NMODE = 4;

    typedef struct {
        logic [W-1:0] data;
        int           sval;
        bit           rail;
        int           due;
        int           finLen;
    } txn_t;

    logic clk = 1'b0;
    logic rst_L = 1'b0;
    logic arm = 1'b0;
    logic [W-1:0] curWord = '0;

    logic         convArr [NMODE];
    logic         sckArr  [NMODE];
    logic [W-1:0] measArr [NMODE];
    logic         finArr  [NMODE];
    logic         railArr [NMODE];

    txn_t expQ [NMODE][$];
    int   convRises [NMODE];
    int   issued = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic polOf(input int m);
        return (m < 2) ? 1'b1 : 1'b0;
    endfunction

    genvar m;
    generate
        for (m = 0; m < NMODE; m++) begin : g_mode
            localparam int POL = (m < 2) ? 1 : 0;
            localparam int PHA = m % 2;

            logic adcIn = 1'b0;
            logic adcConv;
            logic adcSck;
            logic lastSck;
            int   edges = 0;

            adc_sample_reader #(
                .POLARITY(POL),
                .PHASE   (PHA)
            ) dut (
                .clk     (clk),
                .rst_L   (rst_L),
                .arm     (arm),
                .adc_conv(adcConv),
                .adc_sck (adcSck),
                .adc_in  (adcIn),
                .measured(measArr[m]),
                .finished(finArr[m])
`ifdef ADC_RAIL_DETECT_EN
                ,
                .railed  (railArr[m])
`endif
            );

            assign convArr[m] = adcConv;
            assign sckArr[m]  = adcSck;
`ifndef ADC_RAIL_DETECT_EN
            assign railArr[m] = 1'b0;
`endif

            // ADC model: after the convert strobe, bit k (MSB first) is
            // valid across the SCK edge the reader samples on. PHASE=0
            // presents a bit before each leading edge and changes it on the
            // trailing edge; PHASE=1 changes it on the leading edge.
            always @(adcConv or adcSck) begin
                if (adcSck !== lastSck) begin
                    lastSck = adcSck;
                    edges++;
                    if (PHA == 0) begin
                        if (edges % 2 == 0 && edges / 2 < W) adcIn = curWord[W - 1 - edges / 2];
                    end else begin
                        if (edges % 2 == 1 && edges / 2 < W) adcIn = curWord[W - 1 - edges / 2];
                    end
                end else if (!adcConv) begin
                    edges = 0;
                    if (PHA == 0) adcIn = curWord[W-1];
                end else begin
                    edges = 0;
                end
            end

            // Monitor: conversion width, SCK toggle count, latency, sample
            // value and finished pulse length for each completed read.
            int   convLen = 0;
            int   toggles = 0;
            int   finLen = 0;
            logic prevConv = 1'b0;
            logic prevSck = 1'b0;
            logic prevFin = 1'b0;
            bit   have = 1'b0;
            txn_t cur;

            always @(negedge clk) begin
                if (!rst_L) begin
                    convLen = 0;
                    finLen  = 0;
                    have    = 1'b0;
                end else begin
                    if (adcConv) begin
                        if (!prevConv) begin
                            toggles = 0;
                            convRises[m]++;
                        end
                        convLen++;
                    end else if (prevConv) begin
                        checkOutput($sformatf("m%0d convLen", m), convLen, CW);
                        convLen = 0;
                    end
                    if (adcSck !== prevSck) toggles++;

                    if (finArr[m] && !prevFin) begin
                        if (expQ[m].size() == 0) begin
                            checkOutput($sformatf("m%0d unexpectedFinished", m), 1, 0);
                        end else begin
                            cur  = expQ[m].pop_front();
                            have = 1'b1;
                            checkOutput($sformatf("m%0d measured", m), measArr[m], cur.data);
                            checkOutput($sformatf("m%0d signed", m), $signed(measArr[m]), cur.sval);
                            checkOutput($sformatf("m%0d latency", m), cyc, cur.due);
                            checkOutput($sformatf("m%0d sckToggles", m), toggles, 2 * W);
                            checkOutput($sformatf("m%0d sckIdle", m), adcSck, POL);
`ifdef ADC_RAIL_DETECT_EN
                            checkOutput($sformatf("m%0d railed", m), railArr[m], cur.rail);
`endif
                        end
                        finLen = 0;
                    end
                    if (finArr[m]) begin
                        finLen++;
                    end else if (prevFin && have) begin
                        checkOutput($sformatf("m%0d finLen", m), finLen, cur.finLen);
                        have = 1'b0;
                    end
                end
                prevConv = adcConv;
                prevSck  = adcSck;
                prevFin  = finArr[m];
            end
        end
    endgenerate

    task automatic checkReset();
        for (int i = 0; i < NMODE; i++) begin
            checkOutput($sformatf("m%0d rstConv", i), convArr[i], 0);
            checkOutput($sformatf("m%0d rstSck", i), sckArr[i], polOf(i));
            checkOutput($sformatf("m%0d rstMeasured", i), measArr[i], 0);
            checkOutput($sformatf("m%0d rstFinished", i), finArr[i], 0);
`ifdef ADC_RAIL_DETECT_EN
            checkOutput($sformatf("m%0d rstRailed", i), railArr[i], 0);
`endif
        end
    endtask

    task automatic waitFinished(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < LAT + 50 && !seen; i++) begin
            @(negedge clk);
            if (finArr[0]) seen = 1'b1;
        end
        if (!seen) checkOutput("finishedTimeout", 0, 1);
    endtask

    // Starts one read of 'word'. hold = extra cycles arm stays high after
    // finished is seen; earlyDrop releases arm a few cycles into SHIFT.
    task automatic applyStimulus(input logic [W-1:0] word, input int hold, input bit earlyDrop);
        txn_t t;
        bit   seen;
        int   v;
        curWord = word;
        @(negedge clk);
        arm = 1'b1;
        issued++;
        v = int'(word);
        if (v >= (1 << (W - 1))) v = v - (1 << W);
        t.data   = word;
        t.sval   = v;
        t.rail   = (v == (1 << (W - 1)) - 1) || (v == -(1 << (W - 1)));
        t.due    = cyc + 1 + LAT;
        t.finLen = earlyDrop ? 1 : hold + 1;
        for (int i = 0; i < NMODE; i++) expQ[i].push_back(t);
        if (earlyDrop) begin
            repeat (CW + 5) @(negedge clk);
            arm = 1'b0;
        end
        waitFinished(seen);
        if (!earlyDrop) repeat (hold) @(negedge clk);
        arm = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Starts a read and resets the block after nine bits have been shifted.
    task automatic resetMidShift(input logic [W-1:0] word);
        curWord = word;
        @(negedge clk);
        arm = 1'b1;
        issued++;
        repeat (CW + 9 * 2 * (CHW + 1) + 1) @(negedge clk);
        rst_L = 1'b0;
        arm   = 1'b0;
        repeat (3) @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);
        checkReset();
        for (int i = 0; i < NMODE; i++) expQ[i].delete();
    endtask

    initial begin
        for (int i = 0; i < NMODE; i++) convRises[i] = 0;
        rst_L = 1'b0;
        arm   = 1'b0;
        repeat (3) @(negedge clk);
        rst_L = 1'b1;
        @(negedge clk);
        checkReset();

        applyStimulus(18'h1ABCD, 3, 1'b0);
        applyStimulus(18'h20000, 0, 1'b0);
        applyStimulus(18'h1FFFF, 0, 1'b0);
        applyStimulus(18'h00001, 0, 1'b0);
        applyStimulus(18'h2A5A5, 10, 1'b0);
        applyStimulus(W'($urandom), 0, 1'b1);

        resetMidShift(18'h3C3C3);
        applyStimulus(18'h15A5A, 1, 1'b0);

        for (int n = 0; n < 6; n++) begin
            applyStimulus(W'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        for (int i = 0; i < NMODE; i++) begin
            checkOutput($sformatf("m%0d pendingExpected", i), expQ[i].size(), 0);
            checkOutput($sformatf("m%0d convPulses", i), convRises[i], issued);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_sample_reader.md
Name: adc_sample_reader

Overview:
- Upstream acquisition stage for the PI control loop.
- Pulses the ADC convert line, waits the conversion time, then clocks ADC_WID bits in from the ADC serial output, MSB first.
- Presents the result as a signed two's-complement sample, which feeds the loop's error calculation (measured - setpoint).
- Uses the same arm/finished handshake as the loop's other SPI stages.

Parameters:
- ADC_WID, 18, sample width in bits (two's complement).
- WID_LEN, 5, bit-counter width; must hold ADC_WID.
- CONV_WAIT, 20, clk cycles adc_conv is held high before read-out (≥1).
- CONV_WAIT_LEN, 6, width of the conversion timer.
- CYCLE_HALF_WAIT, 1, extra clk cycles per SCK half-period; half-period = CYCLE_HALF_WAIT+1 clks.
- TIMER_LEN, 3, width of the half-period timer.
- POLARITY, 1, SCK idle level.
- PHASE, 0, 0 = sample miso on the leading SCK edge; 1 = sample on the trailing edge.

Ports:
- clk  in  1  system clock.
- rst_L  in  1  synchronous reset, active low.
- arm  in  1  start request; level-sensitive, held by the consumer until finished.
- adc_conv  out  1  convert strobe to the ADC, active high.
- adc_sck  out  1  serial clock to the ADC.
- adc_in  in  1  ADC serial data (MISO).
- measured  out  ADC_WID  last completed sample, signed.
- finished  out  1  sample valid / transaction done.

Behaviour:
- Reset values (rst_L=0 at a clk edge): adc_conv=0, adc_sck=POLARITY, measured=0, finished=0, state=IDLE, all timers and the shift register cleared.
- Reset takes effect from any state, including mid-conversion and mid-shift; no partial sample is ever committed to measured.
- States: IDLE -> CONV -> SHIFT -> DONE -> IDLE.
- IDLE:
  - On the edge where arm=1, go to CONV; adc_conv=1 from the next cycle.
  - While in IDLE, adc_sck stays at POLARITY.
- CONV:
  - adc_conv is held high for exactly CONV_WAIT cycles.
  - Then adc_conv=0 and the FSM enters SHIFT.
- SHIFT:
  - Generates exactly ADC_WID SCK periods (2*ADC_WID toggles); each level lasts CYCLE_HALF_WAIT+1 clks.
  - adc_in is sampled on the leading edge (PHASE=0) or the trailing edge (PHASE=1) of each period.
  - Bits shift in MSB first.
  - After the final toggle, adc_sck equals POLARITY.
- Entering DONE:
  - The shift register is copied to measured and finished=1 in the same cycle.
  - Latency: finished rises exactly 1 + CONV_WAIT + 2*ADC_WID*(CYCLE_HALF_WAIT+1) clks after the edge that sampled arm=1. With default parameters this is 93.
- DONE:
  - Holds finished=1 and measured stable while arm=1.
  - When arm=0 is sampled: finished=0 on the next cycle, and the FSM returns to IDLE.
  - A new transaction needs arm to be seen low, then high again. There is no back-to-back retrigger while arm stays high.
- arm deasserted during CONV or SHIFT:
  - It is ignored; the transaction completes.
  - finished pulses for exactly one cycle, then the FSM returns to IDLE.
- measured changes only on entry to DONE. It is never updated mid-shift.
- Sign: bit ADC_WID-1 is the sign bit. No extension inside the block; the consumer sign-extends.

Optional Feature:
- Macro: ADC_RAIL_DETECT_EN.
- When defined:
  - Adds output port railed (1 bit, reset 0).
  - railed is updated together with measured on entry to DONE.
  - railed=1 iff the sample equals 2^(ADC_WID-1)-1 or -2^(ADC_WID-1).
  - railed holds its value until the next sample completes.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive rst_L=0 for 3 cycles, then release → adc_conv=0, adc_sck=1, measured=0, finished=0.
- Basic read, defaults: the ADC model returns 18'h1ABCD on arm → adc_conv high for exactly 20 cycles, 18 SCK periods of 4 clks each, finished rises 93 clks after arm is sampled, measured=18'h1ABCD.
- Negative/rail values: samples 18'h20000 and 18'h1FFFF → measured read back signed as -131072 and +131071. With ADC_RAIL_DETECT_EN, railed=1 for both; a sample of 18'h00001 gives railed=0.
- Handshake:
  - Hold arm=1 after finished → no second conv pulse.
  - Drop arm → finished=0 one cycle later.
  - Raise arm again → a new conv pulse starts.
- Early arm drop: deassert arm 5 cycles into SHIFT → the transaction completes, finished is high for exactly 1 cycle, and measured is updated.
- Reset mid-SHIFT: pull rst_L=0 after 9 bits → outputs return to reset values, measured keeps 0 (not the partial sample), and the next armed read returns the correct value.
- Sweep PHASE={0,1} × POLARITY={0,1} against a matching ADC model → all four modes read back 18'h2A5A5 correctly.
